// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// Latency: request sampled in IDLE (cycle 0), ack pulse in cycle 3; one access per 4 cycles.
// Backpressure: requesters hold req and fields until ack; losing or late requests simply wait in IDLE.
module mem_arbiter #(
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          mem_we_n,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  state_t        state;
  logic          gnt_r;
  logic          last_grant;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          gnt_sel;
  logic          in_range;

  // Address is valid only when every bit above the implemented word index is zero.
  assign in_range = ((addr_r >> IW) == '0);

  // Memory side always reflects the latched request; rst kills a write immediately.
  assign mem_addr = addr_r;
  assign mem_din  = wdata_r;
  assign mem_we_n = ~((state == ACCESS) && we_r && in_range && !rst);
  assign busy     = (state != IDLE);

  // Lone requester wins outright; on a tie the port not granted last time wins.
  always_comb begin
    gnt_sel = 1'b0;
    if (req0 && req1) gnt_sel = ~last_grant;
    else              gnt_sel = req1;
  end

  // Access sequencer: latch request, drive memory, capture read data, pulse ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt_r      <= 1'b0;
      last_grant <= 1'b1;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt_r      <= gnt_sel;
            last_grant <= gnt_sel;
            we_r       <= gnt_sel ? we1    : we0;
            addr_r     <= gnt_sel ? addr1  : addr0;
            wdata_r    <= gnt_sel ? wdata1 : wdata0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          // Out-of-range zeroes rdata; in-range reads take mem_dout; in-range writes keep rdata.
          if (gnt_r) begin
            if (!in_range)  rdata1 <= '0;
            else if (!we_r) rdata1 <= mem_dout;
            ack1 <= 1'b1;
            err1 <= !in_range;
          end else begin
            if (!in_range)  rdata0 <= '0;
            else if (!we_r) rdata0 <= mem_dout;
            ack0 <= 1'b1;
            err0 <= !in_range;
          end
          state <= DONE;
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err0  <= 1'b0;
          err1  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
